// File: rtl/avs_pkg.sv
// Shared definitions for the AVS processing chain: FSM states, default sample
// and window geometry, and the accumulator width derivation.
package avs_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int WIDTH_DEF  = 16;
    localparam int LEN_DEF    = 128;
    localparam int LOGLEN_DEF = 7;

    // A full window of worst-case products must fit without wrapping.
    function automatic int accw_of(input int width, input int loglen);
        return 2 * width + loglen;
    endfunction

    localparam int ACCW_DEF = accw_of(WIDTH_DEF, LOGLEN_DEF);

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane: sum loads a*b on load, adds a*b on acc_en.
// next_sum exposes the running total including the current product.
module mac_lane
    import avs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACCW  = ACCW_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    acc_en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACCW-1:0]  sum,
    output logic signed [ACCW-1:0]  next_sum
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    prod_ext;
    logic signed [ACCW-1:0]    sum_reg;

    assign prod     = a * b;
    assign prod_ext = {{(ACCW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign next_sum = sum_reg + prod_ext;
    assign sum      = sum_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_reg <= '0;
        end else if (load) begin
            sum_reg <= prod_ext;
        end else if (acc_en) begin
            sum_reg <= next_sum;
        end
    end

endmodule

// File: rtl/intensity_accum.sv
// Windowed active-intensity integrator: sums pressure*vectorx and pressure*vectory
// over LEN samples after a trigger and offers the result on a valid/ready slot.
module intensity_accum
    import avs_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int LEN    = LEN_DEF,
    parameter int LOGLEN = LOGLEN_DEF,
    parameter int ACCW   = accw_of(WIDTH, LOGLEN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] pressure,
    input  logic signed [WIDTH-1:0] vectorx,
    input  logic signed [WIDTH-1:0] vectory,
    input  logic [5:0]              freqbin,
    input  logic                    result_ready,
    output logic signed [ACCW-1:0]  intensx,
    output logic signed [ACCW-1:0]  intensy,
    output logic [5:0]              binout,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    overrun
);

    state_t                  state_reg;
    logic [LOGLEN-1:0]       count_reg;
    logic signed [ACCW-1:0]  intensx_reg;
    logic signed [ACCW-1:0]  intensy_reg;
    logic [5:0]              binout_reg;
    logic                    valid_reg;
    logic                    busy_reg;
    logic                    overrun_reg;

    logic                    load;
    logic                    acc_en;
    logic                    done;
    logic                    slot_free;

    logic signed [WIDTH-1:0] lane_b [2];
    logic signed [ACCW-1:0]  lane_sum_unused [2];
    logic signed [ACCW-1:0]  lane_next [2];

    assign load      = (state_reg == IDLE) && enable;
    assign acc_en    = (state_reg == ACCUM);
    assign done      = acc_en && (count_reg == LOGLEN'(LEN - 1));
    assign slot_free = !valid_reg || result_ready;

    assign lane_b[0] = vectorx;
    assign lane_b[1] = vectory;

    // Lane 0 integrates p*vx, lane 1 integrates p*vy.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            mac_lane #(
                .WIDTH(WIDTH),
                .ACCW (ACCW)
            ) u_mac (
                .clock   (clock),
                .reset   (reset),
                .load    (load),
                .acc_en  (acc_en),
                .a       (pressure),
                .b       (lane_b[gi]),
                .sum     (lane_sum_unused[gi]),
                .next_sum(lane_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            intensx_reg <= '0;
            intensy_reg <= '0;
            binout_reg  <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= ACCUM;
                        count_reg <= LOGLEN'(1);
                        busy_reg  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (done) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        count_reg <= count_reg + LOGLEN'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase

            // A completing window only lands if the consumer has room; otherwise
            // the held result stays put and the loss is flagged.
            if (done && slot_free) begin
                intensx_reg <= lane_next[0];
                intensy_reg <= lane_next[1];
                binout_reg  <= freqbin;
                valid_reg   <= 1'b1;
            end else if (result_ready) begin
                valid_reg   <= 1'b0;
            end

            if (done && !slot_free) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign intensx      = intensx_reg;
    assign intensy      = intensy_reg;
    assign binout       = binout_reg;
    assign result_valid = valid_reg;
    assign busy         = busy_reg;
    assign overrun      = overrun_reg;

endmodule
